fuel_pump_auth: RTL

Parametrised successor of the anti-theft fuel pump interlock. With ignition on and brake held, the driver enters a serial CODE_LEN-bit code on the hidden switch. The pump is enabled only on a correct code. Wrong codes and entry timeouts count as failed attempts; MAX_TRIES consecutive failures force a timed lockout with the alarm raised. The block sits between the debounced cabin inputs and the fuel pump relay driver.

---
 rtl/fuel_pump_auth_pkg.sv | 19 +
 rtl/fuel_pump_auth_cycle_timer.sv | 27 ++
 rtl/fuel_pump_auth.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fuel_pump_auth_pkg.sv
// Shared anti-theft definitions: 3-bit state encodings and counter width helpers.
package fuel_pump_auth_pkg;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StIgnOn   = 3'd1;
  localparam logic [2:0] StEntry   = 3'd2;
  localparam logic [2:0] StFuelOn  = 3'd3;
  localparam logic [2:0] StLockout = 3'd4;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned try_width(input int unsigned max_tries);
    return $clog2(max_tries + 1);
  endfunction

endpackage

// File: rtl/fuel_pump_auth_cycle_timer.sv
// Saturating up-counter: clears to zero, counts while enabled, holds at terminal.
module fuel_pump_auth_cycle_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic             done
);

  logic [WIDTH-1:0] count_q;

  assign done = (count_q == terminal);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !done) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fuel_pump_auth.sv
// Fuel pump interlock: serial code entry under ignition+brake, retry limit, timed lockout.
module fuel_pump_auth
  import fuel_pump_auth_pkg::*;
#(
  parameter int unsigned          CODE_LEN    = 4,
  parameter logic [CODE_LEN-1:0]  CODE        = 4'b1011,
  parameter int unsigned          MAX_TRIES   = 3,
  parameter int unsigned          TIMEOUT_CYC = 16,
  parameter int unsigned          LOCK_CYC    = 64,
  localparam int unsigned         TRY_W       = try_width(MAX_TRIES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ignition,
  input  logic             brake,
  input  logic             hidden_sw,
  input  logic             code_strobe,
  output logic             fuel_pump,
  output logic             alarm,
  output logic             entry_active,
  output logic [TRY_W-1:0] attempts
);

  localparam int unsigned BIT_W  = cnt_width(CODE_LEN);
  localparam int unsigned TMO_W  = cnt_width(TIMEOUT_CYC);
  localparam int unsigned LOCK_W = cnt_width(LOCK_CYC);

  logic [2:0]          state_q, state_d;
  logic [TRY_W-1:0]    fail_q, fail_d, fail_inc;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [CODE_LEN-1:0] shift_q, shift_d, shift_next;
  logic                entry_clear, lock_clear, entry_done, lock_done, failed;

  assign shift_next = CODE_LEN'({shift_q, hidden_sw});
  assign fail_inc   = (fail_q == TRY_W'(MAX_TRIES)) ? fail_q : fail_q + TRY_W'(1);

  always_comb begin
    state_d     = state_q;
    fail_d      = fail_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    entry_clear = 1'b0;
    lock_clear  = 1'b0;
    failed      = 1'b0;
    case (state_q)
      StIdle: begin
        if (ignition) state_d = StIgnOn;
      end
      StIgnOn: begin
        if (!ignition) begin
          state_d = StIdle;
        end else if (brake) begin
          state_d     = StEntry;
          bit_d       = '0;
          shift_d     = '0;
          entry_clear = 1'b1;
        end
      end
      StEntry: begin
        if (!ignition) begin
          state_d = StIdle;
        end else if (!brake) begin
          state_d = StIgnOn;
        end else if (code_strobe && (bit_q == BIT_W'(CODE_LEN - 1))) begin
          // A completing strobe wins over a coincident timeout.
          shift_d = shift_next;
          bit_d   = '0;
          if (shift_next == CODE) begin
            state_d = StFuelOn;
            fail_d  = '0;
          end else begin
            failed = 1'b1;
          end
        end else begin
          if (code_strobe) begin
            shift_d = shift_next;
            bit_d   = bit_q + BIT_W'(1);
          end
          if (entry_done) failed = 1'b1;
        end
        if (failed) begin
          fail_d = fail_inc;
          if (fail_inc == TRY_W'(MAX_TRIES)) begin
            state_d    = StLockout;
            lock_clear = 1'b1;
          end else begin
            state_d = StIgnOn;
          end
        end
      end
      StFuelOn: begin
        if (!ignition) state_d = StIdle;
      end
      StLockout: begin
        if (lock_done) begin
          state_d = StIdle;
          fail_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      fail_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  fuel_pump_auth_cycle_timer #(
    .WIDTH (TMO_W)
  ) u_entry_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (entry_clear),
    .enable   (state_q == StEntry),
    .terminal (TMO_W'(TIMEOUT_CYC - 1)),
    .done     (entry_done)
  );

  fuel_pump_auth_cycle_timer #(
    .WIDTH (LOCK_W)
  ) u_lock_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (lock_clear),
    .enable   (state_q == StLockout),
    .terminal (LOCK_W'(LOCK_CYC - 1)),
    .done     (lock_done)
  );

  assign fuel_pump    = (state_q == StFuelOn);
  assign alarm        = (state_q == StLockout);
  assign entry_active = (state_q == StEntry);
  assign attempts     = fail_q;

endmodule
